rq_tx_mux_n: RTL and testbench

N-channel packet-atomic multiplexer for the PCIe Requester Request (RQ) AXI-Stream interface, sitting between the DMA request sources (data write, completion write, credit/poll reads) and the hard-IP `m_axis_rq` port. It generalises the fixed six-source TX arbiter. Channel count and data width are parameters, per-channel arbitration weights are programmable, and `m_axis_rq_tuser` byte enables are derived from each packet's descriptor. A 2-entry skid buffer on the output sustains full throughput under `m_axis_rq_tready` backpressure.

---
 rtl/rq_tx_mux_n.sv | 220 ++++++++++++++++++++++
 tb/tb_rq_tx_mux_n.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rq_tx_mux_n.sv
// N-channel packet-atomic weighted round-robin mux onto the PCIe RQ AXI-Stream port,
// with descriptor-derived tuser byte enables and a 2-entry output skid buffer.
// Optional per-channel accepted-packet counters: define RQ_TX_PKT_CNT_EN.
module rq_tx_mux_n #(
  parameter int NUM_CH   = 4,
  parameter int DATA_W   = 512,
  parameter int KEEP_W   = DATA_W / 32,
  parameter int TUSER_W  = 137,
  parameter int WEIGHT_W = 4
) (
  input  logic                         user_clk,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            s_axis_tvalid,
  input  logic [NUM_CH*DATA_W-1:0]     s_axis_tdata,
  input  logic [NUM_CH*KEEP_W-1:0]     s_axis_tkeep,
  input  logic [NUM_CH-1:0]            s_axis_tlast,
  output logic [NUM_CH-1:0]            s_axis_tready,
  output logic                         m_axis_rq_tvalid,
  output logic [DATA_W-1:0]            m_axis_rq_tdata,
  output logic [KEEP_W-1:0]            m_axis_rq_tkeep,
  output logic                         m_axis_rq_tlast,
  output logic [TUSER_W-1:0]           m_axis_rq_tuser,
  input  logic                         m_axis_rq_tready,
  input  logic [NUM_CH*WEIGHT_W-1:0]   reg_arb_weight,
  output logic [2:0]                   grant_ch,
  input  logic                         en_pkt_cnt,
  input  logic                         rst_pkt_cnt,
  output logic [NUM_CH*32-1:0]         pkt_cnt
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic {IDLE, XFER} state_t;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic [KEEP_W-1:0]  keep;
    logic               last;
    logic [TUSER_W-1:0] user;
  } beat_t;

  state_t              state;
  logic [CH_W-1:0]     ptr_q;
  logic [CH_W-1:0]     gnt_q;
  logic [WEIGHT_W-1:0] credit;
  logic                first_beat;
  logic [TUSER_W-1:0]  held_user;

  beat_t               buf_q [2];
  logic                wr_idx;
  logic                rd_idx;
  logic [1:0]          count;

  logic [WEIGHT_W-1:0] weight [NUM_CH];
  logic [NUM_CH-1:0]   req;
  logic                keep_grant;
  logic [CH_W-1:0]     scan_base;
  logic [CH_W-1:0]     cand;
  logic                win_found;
  logic [CH_W-1:0]     win_idx;

  logic                full;
  logic                accept;
  logic                pop;
  logic [DATA_W-1:0]   in_data;
  logic [KEEP_W-1:0]   in_keep;
  logic                in_last;
  logic [10:0]         in_dw;
  logic [TUSER_W-1:0]  first_user;
  beat_t               in_beat;

  // A zero weight removes the channel from arbitration entirely.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      weight[i] = reg_arb_weight[i*WEIGHT_W +: WEIGHT_W];
      req[i]    = s_axis_tvalid[i] && (weight[i] != '0);
    end
  end

  assign keep_grant = (credit != '0) && req[gnt_q];

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    scan_base = ((credit != '0) && !req[gnt_q]) ? gnt_q : ptr_q;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = CH_W'((int'(scan_base) + k) % NUM_CH);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign full    = (count == 2'd2);
  assign accept  = (state == XFER) && !full && s_axis_tvalid[gnt_q];
  assign pop     = (count != 2'd0) && m_axis_rq_tready;
  assign in_data = s_axis_tdata[int'(gnt_q)*DATA_W +: DATA_W];
  assign in_keep = s_axis_tkeep[int'(gnt_q)*KEEP_W +: KEEP_W];
  assign in_last = s_axis_tlast[gnt_q];
  assign in_dw   = in_data[74:64];

  always_comb begin
    s_axis_tready = '0;
    if ((state == XFER) && !full) s_axis_tready[gnt_q] = 1'b1;
  end

  // dw==0 encodes 1024 dwords, so only an exact single-dword request clears last_be.
  always_comb begin
    first_user        = '0;
    first_user[3:0]   = 4'hF;
    first_user[11:8]  = (in_dw == 11'd1) ? 4'h0 : 4'hF;
  end

  always_comb begin
    in_beat.data = in_data;
    in_beat.keep = in_keep;
    in_beat.last = in_last;
    in_beat.user = first_beat ? first_user : held_user;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      ptr_q      <= CH_W'(NUM_CH - 1);
      gnt_q      <= '0;
      credit     <= '0;
      first_beat <= 1'b1;
      held_user  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (keep_grant) begin
            state <= XFER;
          end else begin
            // Granted channel went quiet with quota left: forfeit it and move on.
            if (credit != '0) begin
              ptr_q  <= gnt_q;
              credit <= '0;
            end
            if (win_found) begin
              state  <= XFER;
              gnt_q  <= win_idx;
              credit <= weight[win_idx];
            end
          end
        end
        XFER: begin
          if (accept) begin
            if (first_beat) held_user <= first_user;
            first_beat <= in_last;
            if (in_last) begin
              state  <= IDLE;
              credit <= credit - 1'b1;
              if (credit == WEIGHT_W'(1)) ptr_q <= gnt_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the two buffer entries are reset because the head entry drives the outputs directly.
  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int e = 0; e < 2; e++) buf_q[e] <= '0;
      wr_idx <= 1'b0;
      rd_idx <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (accept) begin
        buf_q[wr_idx] <= in_beat;
        wr_idx        <= ~wr_idx;
      end
      if (pop) rd_idx <= ~rd_idx;
      case ({accept, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign m_axis_rq_tvalid = (count != 2'd0);
  assign m_axis_rq_tdata  = buf_q[rd_idx].data;
  assign m_axis_rq_tkeep  = buf_q[rd_idx].keep;
  assign m_axis_rq_tlast  = buf_q[rd_idx].last;
  assign m_axis_rq_tuser  = buf_q[rd_idx].user;
  assign grant_ch         = 3'(gnt_q);

`ifdef RQ_TX_PKT_CNT_EN
  logic [31:0] cnt_q [NUM_CH];

  always_ff @(posedge user_clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_CH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (rst_pkt_cnt)
          cnt_q[i] <= '0;
        else if (en_pkt_cnt && accept && in_last && (gnt_q == CH_W'(i)))
          cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) pkt_cnt[i*32 +: 32] = cnt_q[i];
  end
`else
  logic unused_cnt_ctrl;
  assign unused_cnt_ctrl = en_pkt_cnt ^ rst_pkt_cnt;
  assign pkt_cnt         = '0;
`endif

endmodule

// File: tb/tb_rq_tx_mux_n.sv
// Scoreboard bench for rq_tx_mux_n: per-channel source queues feed the DUT, expected
// beats are queued in hand-derived order and a monitor compares every output beat.
module tb_rq_tx_mux_n;
  localparam int NUM_CH   = 4;
  localparam int DATA_W   = 512;
  localparam int KEEP_W   = DATA_W / 32;
  localparam int TUSER_W  = 137;
  localparam int WEIGHT_W = 4;

  logic                       user_clk = 1'b0;
  logic                       reset_n  = 1'b0;
  logic [NUM_CH-1:0]          s_axis_tvalid;
  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata;
  logic [NUM_CH*KEEP_W-1:0]   s_axis_tkeep;
  logic [NUM_CH-1:0]          s_axis_tlast;
  logic [NUM_CH-1:0]          s_axis_tready;
  logic                       m_axis_rq_tvalid;
  logic [DATA_W-1:0]          m_axis_rq_tdata;
  logic [KEEP_W-1:0]          m_axis_rq_tkeep;
  logic                       m_axis_rq_tlast;
  logic [TUSER_W-1:0]         m_axis_rq_tuser;
  logic                       m_axis_rq_tready;
  logic [NUM_CH*WEIGHT_W-1:0] reg_arb_weight;
  logic [2:0]                 grant_ch;
  logic                       en_pkt_cnt;
  logic                       rst_pkt_cnt;
  logic [NUM_CH*32-1:0]       pkt_cnt;

  rq_tx_mux_n #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .KEEP_W(KEEP_W), .TUSER_W(TUSER_W), .WEIGHT_W(WEIGHT_W)
  ) dut (
    .user_clk(user_clk), .reset_n(reset_n),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
    .m_axis_rq_tvalid(m_axis_rq_tvalid), .m_axis_rq_tdata(m_axis_rq_tdata),
    .m_axis_rq_tkeep(m_axis_rq_tkeep), .m_axis_rq_tlast(m_axis_rq_tlast),
    .m_axis_rq_tuser(m_axis_rq_tuser), .m_axis_rq_tready(m_axis_rq_tready),
    .reg_arb_weight(reg_arb_weight), .grant_ch(grant_ch),
    .en_pkt_cnt(en_pkt_cnt), .rst_pkt_cnt(rst_pkt_cnt), .pkt_cnt(pkt_cnt)
  );

  always #5 user_clk = ~user_clk;

  typedef struct {
    logic [DATA_W-1:0]  data;
    logic [KEEP_W-1:0]  keep;
    logic               last;
    logic [TUSER_W-1:0] user;
  } beat_t;

  beat_t src_q [NUM_CH][$];
  beat_t exp_q [$];
  int    acc_cyc_q [$];
  int    out_cyc_q [$];
  int    cyc = 0;
  int    tests = 0;
  int    fails = 0;
  logic  toggle_en = 1'b0;
  logic  ch2_ready_seen = 1'b0;
  logic [NUM_CH-1:0] fire;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Non-first beats carry dw=1 in the descriptor field so a per-beat recompute would show.
  function automatic beat_t mk_beat(int ch, int pkt, int idx, int nbeats, int dw);
    beat_t      b;
    logic [31:0] word;
    word         = 32'hC0DE_0000 + 32'(ch * 4096 + pkt * 64 + idx);
    b.data       = {(DATA_W/32){word}};
    b.data[74:64] = (idx == 0) ? 11'(dw) : 11'd1;
    b.keep       = '1;
    if (idx == nbeats - 1) b.keep = b.keep >> (KEEP_W / 2);
    b.last       = (idx == nbeats - 1);
    b.user       = (dw == 1) ? TUSER_W'(12'h00F) : TUSER_W'(12'hF0F);
    return b;
  endfunction

  task automatic send_pkt(input int ch, input int pkt, input int nbeats, input int dw);
    for (int i = 0; i < nbeats; i++) src_q[ch].push_back(mk_beat(ch, pkt, i, nbeats, dw));
  endtask

  task automatic expect_pkt(input int ch, input int pkt, input int nbeats, input int dw);
    for (int i = 0; i < nbeats; i++) exp_q.push_back(mk_beat(ch, pkt, i, nbeats, dw));
  endtask

  task automatic wait_drain(input string name, input int max_cyc);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(negedge user_clk);
      n++;
    end
    check({name, "_drain_left"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge user_clk);
  endtask

  task automatic do_reset();
    @(negedge user_clk);
    #3 reset_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    exp_q.delete();
    repeat (2) @(negedge user_clk);
    #3 reset_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_m_tvalid"}, m_axis_rq_tvalid, 0);
    check({tag, "_m_tdata"},  m_axis_rq_tdata, 0);
    check({tag, "_m_tkeep"},  m_axis_rq_tkeep, 0);
    check({tag, "_m_tlast"},  m_axis_rq_tlast, 0);
    check({tag, "_m_tuser"},  m_axis_rq_tuser, 0);
    check({tag, "_s_tready"}, s_axis_tready, 0);
    check({tag, "_grant_ch"}, grant_ch, 0);
    check({tag, "_pkt_cnt"},  pkt_cnt, 0);
  endtask

  initial forever begin
    @(posedge user_clk);
    cyc++;
  end

  initial begin
    m_axis_rq_tready = 1'b1;
    forever begin
      @(negedge user_clk);
      m_axis_rq_tready = toggle_en ? ~m_axis_rq_tready : 1'b1;
    end
  end

  // Source driver: retire the beat accepted at the last edge, present the next one.
  initial begin
    fire          = '0;
    s_axis_tvalid = '0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    forever begin
      @(negedge user_clk);
      for (int c = 0; c < NUM_CH; c++) begin
        if (fire[c] && reset_n && src_q[c].size() > 0) src_q[c].delete(0);
        if (src_q[c].size() > 0) begin
          s_axis_tvalid[c]                   = 1'b1;
          s_axis_tdata[c*DATA_W +: DATA_W]   = src_q[c][0].data;
          s_axis_tkeep[c*KEEP_W +: KEEP_W]   = src_q[c][0].keep;
          s_axis_tlast[c]                    = src_q[c][0].last;
        end else begin
          s_axis_tvalid[c] = 1'b0;
          s_axis_tlast[c]  = 1'b0;
        end
      end
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        fire[c] = s_axis_tvalid[c] && s_axis_tready[c];
        if (fire[c]) acc_cyc_q.push_back(cyc);
      end
    end
  end

  // Monitor: pops on handshake, and while stalled the head must already be the next expected beat.
  initial begin
    beat_t b;
    forever begin
      @(negedge user_clk);
      #2;
      if (reset_n) begin
        if (s_axis_tready[2]) ch2_ready_seen = 1'b1;
        if (m_axis_rq_tvalid) begin
          if (exp_q.size() == 0) begin
            check("spurious_beat", m_axis_rq_tvalid, 0);
          end else if (m_axis_rq_tready) begin
            b = exp_q.pop_front();
            out_cyc_q.push_back(cyc);
            check("out_tdata", m_axis_rq_tdata, b.data);
            check("out_tkeep", m_axis_rq_tkeep, b.keep);
            check("out_tlast", m_axis_rq_tlast, b.last);
            check("out_tuser", m_axis_rq_tuser, b.user);
          end else begin
            b = exp_q[0];
            check("stall_tdata", m_axis_rq_tdata, b.data);
            check("stall_tuser", m_axis_rq_tuser, b.user);
            check("stall_tlast", m_axis_rq_tlast, b.last);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
    $fatal(1);
  end

  initial begin
    int ord [12] = '{0, 0, 0, 1, 3, 3, 0, 0, 0, 1, 3, 3};
    int dws [NUM_CH] = '{1, 2, 5, 0};
    int pk  [NUM_CH];
    int n;

    reg_arb_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    en_pkt_cnt     = 1'b0;
    rst_pkt_cnt    = 1'b0;
    #2;
    check_reset_outputs("por");
    #21 reset_n = 1'b1;

    // Single 3-beat packet: one-cycle latency, back-to-back output beats.
    repeat (2) @(negedge user_clk);
    acc_cyc_q.delete();
    out_cyc_q.delete();
    send_pkt(0, 1, 3, 40);
    expect_pkt(0, 1, 3, 40);
    wait_drain("single", 100);
    check("single_out_beats", out_cyc_q.size(), 3);
    if (out_cyc_q.size() == 3 && acc_cyc_q.size() >= 1) begin
      check("single_latency", out_cyc_q[0], acc_cyc_q[0] + 1);
      check("single_beat1_cyc", out_cyc_q[1], out_cyc_q[0] + 1);
      check("single_beat2_cyc", out_cyc_q[2], out_cyc_q[0] + 2);
    end

    // Equal weights: strict round robin 0,1,2,3.
    do_reset();
    for (int p = 0; p < 3; p++)
      for (int c = 0; c < NUM_CH; c++) begin
        send_pkt(c, p, 1, 1);
        expect_pkt(c, p, 1, 1);
      end
    wait_drain("rr", 200);
    check("rr_last_grant", grant_ch, 3);

    // Weights {3,1,0,2}: 0,0,0,1,3,3 repeating, channel 2 never served.
    do_reset();
    reg_arb_weight = {4'd2, 4'd0, 4'd1, 4'd3};
    ch2_ready_seen = 1'b0;
    for (int i = 0; i < 6; i++) send_pkt(0, i, 1, dws[0]);
    for (int i = 0; i < 2; i++) send_pkt(1, i, 1, dws[1]);
    for (int i = 0; i < 2; i++) send_pkt(2, i, 1, dws[2]);
    for (int i = 0; i < 4; i++) send_pkt(3, i, 1, dws[3]);
    pk = '{default: 0};
    for (int i = 0; i < 12; i++) begin
      expect_pkt(ord[i], pk[ord[i]], 1, dws[ord[i]]);
      pk[ord[i]]++;
    end
    wait_drain("wrr", 300);
    check("wrr_ch2_tready", ch2_ready_seen, 0);

    // 16-beat packet with m_axis_rq_tready toggling every cycle.
    do_reset();
    reg_arb_weight = {4'd1, 4'd1, 4'd1, 4'd1};
    toggle_en = 1'b1;
    send_pkt(1, 7, 16, 16);
    expect_pkt(1, 7, 16, 16);
    wait_drain("bp", 200);
    toggle_en = 1'b0;

    // Reset in the middle of a 5-beat packet, then a clean channel-1 packet.
    do_reset();
    send_pkt(2, 3, 5, 5);
    expect_pkt(2, 3, 5, 5);
    n = 0;
    while (src_q[2].size() > 3 && n < 200) begin
      @(negedge user_clk);
      n++;
    end
    check("midrst_reached_beat2", src_q[2].size() <= 3, 1);
    @(posedge user_clk);
    #1 reset_n = 1'b0;
    for (int c = 0; c < NUM_CH; c++) src_q[c].delete();
    exp_q.delete();
    #2;
    check_reset_outputs("midrst");
    repeat (2) @(negedge user_clk);
    #3 reset_n = 1'b1;
    send_pkt(1, 9, 4, 4);
    expect_pkt(1, 9, 4, 4);
    wait_drain("postrst", 100);

    // Packet counters on channel 2.
    do_reset();
    en_pkt_cnt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send_pkt(2, i, 2, 2);
      expect_pkt(2, i, 2, 2);
    end
    wait_drain("cnt5", 200);
`ifdef RQ_TX_PKT_CNT_EN
    check("cnt_ch2_after5", pkt_cnt[2*32 +: 32], 5);
    check("cnt_ch0_after5", pkt_cnt[0 +: 32], 0);
`else
    check("cnt_tied_zero", pkt_cnt, 0);
`endif
    rst_pkt_cnt = 1'b1;
    send_pkt(2, 5, 1, 1);
    expect_pkt(2, 5, 1, 1);
    wait_drain("cnt6", 100);
    rst_pkt_cnt = 1'b0;
    check("cnt_ch2_after_clr", pkt_cnt[2*32 +: 32], 0);
`ifdef RQ_TX_PKT_CNT_EN
    send_pkt(2, 6, 1, 1);
    expect_pkt(2, 6, 1, 1);
    wait_drain("cnt7", 100);
    check("cnt_ch2_after7", pkt_cnt[2*32 +: 32], 1);
`endif
    en_pkt_cnt = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
